// File: rtl/ldtu_atu_packer.sv
// ADC test unit packer: gathers four G10/G1 sample pairs per frame and
// emits them as four 32-bit lanes with a header, sequence number and strobe.
module ldtu_atu_packer #(
  parameter int unsigned  NBITS_ADC = 12,
  parameter int unsigned  NBITS_32  = 32,
  parameter logic [3:0]   HDR_G10   = 4'b0101,
  parameter logic [3:0]   HDR_G1    = 4'b0110,
  parameter logic [31:0]  IDLE_5A   = 32'h5A5A5A5A
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TEST_ENABLE,
  input  logic                 SAMPLE_VALID,
  input  logic [NBITS_ADC-1:0] DATA_G10,
  input  logic [NBITS_ADC-1:0] DATA_G1,
  input  logic                 FRAME_SYNC,
  output logic [NBITS_32-1:0]  DATA32_ATU_0,
  output logic [NBITS_32-1:0]  DATA32_ATU_1,
  output logic [NBITS_32-1:0]  DATA32_ATU_2,
  output logic [NBITS_32-1:0]  DATA32_ATU_3,
  output logic                 ATU_STROBE,
  output logic                 SeuError
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [3:0]           seq_q, seq_d;
  logic                 strobe_q, strobe_d;
  logic [NBITS_32-1:0]  lane_q [4];
  logic [NBITS_32-1:0]  lane_d [4];
  // Only slots 0..2 are buffered; slot 3 is taken straight from the inputs.
  logic [NBITS_ADC-1:0] g10_buf_q [3];
  logic [NBITS_ADC-1:0] g10_buf_d [3];
  logic [NBITS_ADC-1:0] g1_buf_q [3];
  logic [NBITS_ADC-1:0] g1_buf_d [3];

  // Next-state: frame collection, completion, sync and disable handling.
  always_comb begin
    state_d   = TEST_ENABLE ? StCollect : StIdle;
    phase_d   = phase_q;
    seq_d     = seq_q;
    strobe_d  = 1'b0;
    lane_d    = lane_q;
    g10_buf_d = g10_buf_q;
    g1_buf_d  = g1_buf_q;

    if (!TEST_ENABLE) begin
      phase_d = 2'd0;
      seq_d   = 4'd0;
      for (int i = 0; i < 3; i++) begin
        g10_buf_d[i] = '0;
        g1_buf_d[i]  = '0;
      end
      // Lanes are already idle while in StIdle; only a drop out of collect reloads them.
      if (state_q == StCollect) begin
        for (int i = 0; i < 4; i++) lane_d[i] = IDLE_5A;
      end
    end else if (FRAME_SYNC) begin
      // Sync wins over a completing frame: restart and keep any sample as slot 0.
      seq_d = 4'd0;
      for (int i = 0; i < 3; i++) begin
        g10_buf_d[i] = '0;
        g1_buf_d[i]  = '0;
      end
      if (SAMPLE_VALID) begin
        g10_buf_d[0] = DATA_G10;
        g1_buf_d[0]  = DATA_G1;
        phase_d      = 2'd1;
      end else begin
        phase_d = 2'd0;
      end
    end else if (SAMPLE_VALID) begin
      if (phase_q == 2'd3) begin
        lane_d[0] = {HDR_G10, seq_q, g10_buf_q[0], g10_buf_q[1]};
        lane_d[1] = {HDR_G10, seq_q, g10_buf_q[2], DATA_G10};
        lane_d[2] = {HDR_G1,  seq_q, g1_buf_q[0],  g1_buf_q[1]};
        lane_d[3] = {HDR_G1,  seq_q, g1_buf_q[2],  DATA_G1};
        strobe_d  = 1'b1;
        phase_d   = 2'd0;
        seq_d     = seq_q + 4'd1;
      end else begin
        g10_buf_d[phase_q] = DATA_G10;
        g1_buf_d[phase_q]  = DATA_G1;
        phase_d            = phase_q + 2'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      phase_q  <= 2'd0;
      seq_q    <= 4'd0;
      strobe_q <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= IDLE_5A;
      for (int i = 0; i < 3; i++) begin
        g10_buf_q[i] <= '0;
        g1_buf_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      seq_q     <= seq_d;
      strobe_q  <= strobe_d;
      lane_q    <= lane_d;
      g10_buf_q <= g10_buf_d;
      g1_buf_q  <= g1_buf_d;
    end
  end

  assign DATA32_ATU_0 = lane_q[0];
  assign DATA32_ATU_1 = lane_q[1];
  assign DATA32_ATU_2 = lane_q[2];
  assign DATA32_ATU_3 = lane_q[3];
  assign ATU_STROBE   = strobe_q;
  assign SeuError     = 1'b0;

endmodule

// File: doc/ldtu_atu_packer.md
Name: ldtu_atu_packer

Overview:
- ADC Test Unit (ATU) packer: the stage directly upstream of the output mux.
- Collects raw 12-bit samples from the high-gain (G10) and low-gain (G1) ADC channels.
- Packs them into four 32-bit lanes (DATA32_ATU_0..3) that the output mux forwards when TEST_ENABLE is high.
- Bypasses the compression path so both ADCs can be inspected at full rate during test.

Parameters:
NBITS_ADC, 12, sample width per ADC channel
NBITS_32, 32, output lane width
HDR_G10, 4'b0101, header nibble for G10 words
HDR_G1, 4'b0110, header nibble for G1 words
IDLE_5A, 32'h5A5A5A5A, lane value when not packing

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-low
TEST_ENABLE  in  1  packing enabled when 1
SAMPLE_VALID  in  1  DATA_G10/DATA_G1 hold a new sample pair this cycle
DATA_G10  in  12  high-gain ADC sample
DATA_G1  in  12  low-gain ADC sample
FRAME_SYNC  in  1  one-cycle pulse; restarts frame phase and sequence counter
DATA32_ATU_0  out  32  G10 word, samples 0,1 of frame
DATA32_ATU_1  out  32  G10 word, samples 2,3 of frame
DATA32_ATU_2  out  32  G1 word, samples 0,1 of frame
DATA32_ATU_3  out  32  G1 word, samples 2,3 of frame
ATU_STROBE  out  1  one-cycle pulse: all four lanes updated this cycle
SeuError  out  1  reserved, tied 0

Behaviour:
Reset and idle
- Reset (RST=0 at posedge CLK): all lanes = IDLE_5A; ATU_STROBE=0; phase counter=0; sequence counter SEQ=0; sample buffers cleared.

Frame collection
- State IDLE while TEST_ENABLE=0:
  - lanes hold IDLE_5A; ATU_STROBE=0; phase=0; SEQ=0; SAMPLE_VALID ignored.
- Transition to COLLECT on the first cycle TEST_ENABLE=1.
- In COLLECT, each cycle with SAMPLE_VALID=1 stores DATA_G10 and DATA_G1 in buffer slot [phase] and advances phase 0->1->2->3.
- Cycles with SAMPLE_VALID=0 leave phase and buffers unchanged; gaps are allowed.

Frame completion and output
- When the sample stored in phase 3 arrives (SAMPLE_VALID=1, phase=3), the four lanes are registered on the next posedge. Latency: the lanes and ATU_STROBE=1 appear exactly 1 cycle after the 4th sample is presented.
- Then phase->0 and SEQ increments mod 16 (15 wraps to 0).
- Lane word format, where s0..s3 are the samples of the frame and SEQ is the value before the increment:
  - [31:28] header
  - [27:24] SEQ
  - [23:12] earlier sample
  - [11:0] later sample
- Lane contents:
  - lane0 = {HDR_G10, SEQ, g10_s0, g10_s1}
  - lane1 = {HDR_G10, SEQ, g10_s2, g10_s3}
  - lane2 = {HDR_G1, SEQ, g1_s0, g1_s1}
  - lane3 = {HDR_G1, SEQ, g1_s2, g1_s3}
- Lanes hold their value between strobes. ATU_STROBE is high for exactly one cycle per frame.

Control events
- FRAME_SYNC=1 (TEST_ENABLE=1): phase=0, SEQ=0, partially collected samples discarded; lanes unchanged, no strobe.
  - If SAMPLE_VALID=1 in the same cycle, that sample is stored as slot 0 and phase becomes 1.
  - FRAME_SYNC has priority over a phase-3 completion in the same cycle: no strobe, and the sample becomes slot 0.
- TEST_ENABLE falling mid-frame: next posedge lanes=IDLE_5A, partial frame discarded, phase=0, SEQ=0.
- Reset has priority over all other inputs, including mid-frame.

SEU
- SeuError is constant 0 (no TMR in this version).

Test Plan:
- Reset and idle: RST=0 for 3 cycles, then RST=1 with TEST_ENABLE=0 and 20 cycles of SAMPLE_VALID=1 -> all lanes 32'h5A5A5A5A, ATU_STROBE never 1.
- Single frame: TEST_ENABLE=1, 4 consecutive valid pairs G10=001,002,003,004 and G1=F01,F02,F03,F04 -> one cycle after the 4th sample:
  - lane0=32'h50001002
  - lane1=32'h50003004
  - lane2=32'h60F01F02
  - lane3=32'h60F03F04
  - ATU_STROBE=1 for 1 cycle.
- Gapped input: same samples with SAMPLE_VALID=0 between each -> identical lane values, strobe 1 cycle after the last valid sample.
- Sequence wrap: 17 back-to-back frames -> SEQ field 0..15 then 0; exactly 17 strobes, one every 4 cycles.
- FRAME_SYNC mid-frame: 2 samples, then FRAME_SYNC with a valid sample, then 3 more samples -> strobe after the 4th post-sync sample; words contain only post-sync samples; SEQ=0.
- Disable mid-frame: TEST_ENABLE 1->0 after 2 samples -> next cycle lanes=5A5A5A5A, no strobe. Re-enable and run a full frame -> SEQ=0, correct data.
